// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned PC_STEP            = 4;
   localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0040_0000;

   typedef enum logic [1:0] {
      OUT_EMPTY = 2'd0,
      OUT_ONE   = 2'd1,
      OUT_TWO   = 2'd2
   } out_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_skid_buffer.sv
// Two-entry output buffer (output register plus one skid entry) with valid/ready
// on the consumer side; flush drops both entries but keeps a transfer in that cycle.
module fetch_skid_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             out_ready_i,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             skid_valid_o
);

   out_state_e       state_q, state_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             transfer;

   assign out_valid_o  = (state_q != OUT_EMPTY);
   assign skid_valid_o = (state_q == OUT_TWO);
   assign out_data_o   = out_data_q;
   assign transfer     = out_valid_o && out_ready_i;

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      skid_data_d = skid_data_q;
      unique case (state_q)
         OUT_EMPTY: begin
            if (in_valid_i) begin
               out_data_d = in_data_i;
               state_d    = OUT_ONE;
            end
         end
         OUT_ONE: begin
            if (transfer && in_valid_i) begin
               out_data_d = in_data_i;
            end else if (transfer) begin
               state_d = OUT_EMPTY;
            end else if (in_valid_i) begin
               skid_data_d = in_data_i;
               state_d     = OUT_TWO;
            end
         end
         OUT_TWO: begin
            // Upstream never returns a word while the skid entry is occupied.
            if (transfer) begin
               out_data_d = skid_data_q;
               state_d    = OUT_ONE;
            end
         end
         default: state_d = OUT_EMPTY;
      endcase
      if (flush_i) begin
         state_d = OUT_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= OUT_EMPTY;
         out_data_q  <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         skid_data_q <= skid_data_d;
      end
   end

endmodule : fetch_skid_buffer

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one address per cycle to a 1-cycle-latency
// memory and hands returned words to decode through a two-entry output buffer.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(DEFAULT_RESET_ADDR)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Stall_i,
   input  logic                  Branch_Taken_i,
   input  logic [ADDR_WIDTH-1:0] Branch_Target_i,
   output logic [ADDR_WIDTH-1:0] Address_o,
   input  logic [DATA_WIDTH-1:0] Instruction_i,
   output logic [DATA_WIDTH-1:0] Instr_o,
   output logic [ADDR_WIDTH-1:0] Pc_o,
   output logic                  Instr_Valid_o,
   input  logic                  Ready_i
);

   localparam int unsigned PAYLOAD_W = DATA_WIDTH + ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic                  inflight_q, inflight_d;
   logic                  issue;
   logic                  out_valid;
   logic                  skid_valid;
   logic [PAYLOAD_W-1:0]  ret_payload;
   logic [PAYLOAD_W-1:0]  out_payload;
   logic [1:0]            unused_target_bits;

   assign unused_target_bits = Branch_Target_i[1:0];
   assign Address_o          = pc_q;

   // Hold off when a held output plus a returning word would fill both entries.
   assign issue = !Stall_i && !Branch_Taken_i && !skid_valid &&
                  !(out_valid && !Ready_i && inflight_q);

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      if (Branch_Taken_i) begin
         pc_d = {Branch_Target_i[ADDR_WIDTH-1:2], 2'b00};
      end else if (issue) begin
         inflight_d    = 1'b1;
         inflight_pc_d = pc_q;
         pc_d          = pc_q + ADDR_WIDTH'(PC_STEP);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q          <= RESET_ADDR;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   assign ret_payload = {Instruction_i, inflight_pc_q};

   fetch_skid_buffer #(
      .WIDTH (PAYLOAD_W)
   ) u_skid (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (Branch_Taken_i),
      .in_valid_i   (inflight_q),
      .in_data_i    (ret_payload),
      .out_ready_i  (Ready_i),
      .out_valid_o  (out_valid),
      .out_data_o   (out_payload),
      .skid_valid_o (skid_valid)
   );

   assign Instr_Valid_o = out_valid;
   assign Instr_o       = out_payload[PAYLOAD_W-1:ADDR_WIDTH];
   assign Pc_o          = out_payload[ADDR_WIDTH-1:0];

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: synchronous memory model plus a PC scoreboard
// refilled on every reset/redirect and drained on every decode transfer.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_ADDR = 32'h0040_0000;

   logic        clk;
   logic        rst_n;
   logic        Stall_i;
   logic        Branch_Taken_i;
   logic [31:0] Branch_Target_i;
   logic [31:0] Address_o;
   logic [31:0] Instruction_i;
   logic [31:0] Instr_o;
   logic [31:0] Pc_o;
   logic        Instr_Valid_o;
   logic        Ready_i;

   int n_cmp  = 0;
   int n_err  = 0;
   int n_xfer = 0;
   logic [31:0] exp_q[$];

   instr_fetch_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .Stall_i         (Stall_i),
      .Branch_Taken_i  (Branch_Taken_i),
      .Branch_Target_i (Branch_Target_i),
      .Address_o       (Address_o),
      .Instruction_i   (Instruction_i),
      .Instr_o         (Instr_o),
      .Pc_o            (Pc_o),
      .Instr_Valid_o   (Instr_Valid_o),
      .Ready_i         (Ready_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Synchronous memory: data for the address of cycle n is presented in n+1.
   always @(posedge clk) Instruction_i <= mem_word(Address_o);

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic refill(input logic [31:0] start);
      exp_q.delete();
      for (int i = 0; i < 128; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle scoreboard: a transfer is decided by the values seen here.
   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst_n) begin
         refill(RST_ADDR);
      end else begin
         if (Instr_Valid_o && Ready_i) begin
            check_eq("sb_nonempty", {63'b0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_eq("sb_pc", 64'(Pc_o), 64'(e));
               check_eq("sb_instr", 64'(Instr_o), 64'(mem_word(e)));
               n_xfer++;
               $display("xfer pc=%h instr=%h", Pc_o, Instr_o);
            end
         end
         if (Branch_Taken_i) refill({Branch_Target_i[31:2], 2'b00});
      end
   end

   logic [31:0] a0, hold_pc, hold_instr;

   initial begin
      rst_n = 1'b0; Ready_i = 1'b1; Stall_i = 1'b0;
      Branch_Taken_i = 1'b0; Branch_Target_i = '0;
      repeat (3) tick();
      check_eq("rst_valid", 64'(Instr_Valid_o), 64'd0);
      check_eq("rst_instr", 64'(Instr_o), 64'd0);
      check_eq("rst_pc", 64'(Pc_o), 64'd0);
      check_eq("rst_addr", 64'(Address_o), 64'(RST_ADDR));

      // Start-up latency and streaming
      rst_n = 1'b1;
      check_eq("c0_addr", 64'(Address_o), 64'(RST_ADDR));
      check_eq("c0_valid", 64'(Instr_Valid_o), 64'd0);
      tick();
      check_eq("c1_addr", 64'(Address_o), 64'(RST_ADDR + 32'd4));
      check_eq("c1_valid", 64'(Instr_Valid_o), 64'd0);
      tick();
      check_eq("c2_addr", 64'(Address_o), 64'(RST_ADDR + 32'd8));
      check_eq("c2_valid", 64'(Instr_Valid_o), 64'd1);
      check_eq("c2_pc", 64'(Pc_o), 64'(RST_ADDR));
      repeat (4) tick();

      // Backpressure: outputs stable, fetch freezes, no loss on release
      Ready_i = 1'b0;
      hold_pc = Pc_o; hold_instr = Instr_o;
      check_eq("bp_valid0", 64'(Instr_Valid_o), 64'd1);
      tick();
      a0 = Address_o;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("bp_addr", 64'(Address_o), 64'(a0));
         check_eq("bp_pc", 64'(Pc_o), 64'(hold_pc));
         check_eq("bp_instr", 64'(Instr_o), 64'(hold_instr));
         check_eq("bp_valid", 64'(Instr_Valid_o), 64'd1);
      end
      Ready_i = 1'b1;
      repeat (6) tick();

      // Redirect while both buffer entries are full
      Ready_i = 1'b0;
      repeat (3) tick();
      Branch_Taken_i = 1'b1; Branch_Target_i = 32'h0040_0043;
      tick();
      Branch_Taken_i = 1'b0; Ready_i = 1'b1;
      check_eq("br_addr", 64'(Address_o), 64'h0040_0040);
      check_eq("br_v1", 64'(Instr_Valid_o), 64'd0);
      tick();
      check_eq("br_v2", 64'(Instr_Valid_o), 64'd0);
      tick();
      check_eq("br_v3", 64'(Instr_Valid_o), 64'd1);
      check_eq("br_pc", 64'(Pc_o), 64'h0040_0040);
      repeat (3) tick();

      // Stall: returning word still delivered, PC holds, resumes on release
      Stall_i = 1'b1;
      a0 = Address_o;
      tick();
      check_eq("st_addr1", 64'(Address_o), 64'(a0));
      check_eq("st_ret_valid", 64'(Instr_Valid_o), 64'd1);
      check_eq("st_ret_pc", 64'(Pc_o), 64'(a0 - 32'd4));
      tick();
      check_eq("st_addr2", 64'(Address_o), 64'(a0));
      tick();
      check_eq("st_addr3", 64'(Address_o), 64'(a0));
      Stall_i = 1'b0;
      tick();
      check_eq("st_resume", 64'(Address_o), 64'(a0 + 32'd4));
      repeat (4) tick();

      // Address wrap
      Branch_Taken_i = 1'b1; Branch_Target_i = 32'hFFFF_FFF8;
      tick();
      Branch_Taken_i = 1'b0;
      tick();
      tick();
      check_eq("wr_pc0", 64'(Pc_o), 64'hFFFF_FFF8);
      tick();
      check_eq("wr_pc1", 64'(Pc_o), 64'hFFFF_FFFC);
      tick();
      check_eq("wr_pc2", 64'(Pc_o), 64'h0000_0000);
      repeat (2) tick();

      // Reset with the buffer full
      Ready_i = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      check_eq("rm_valid", 64'(Instr_Valid_o), 64'd0);
      check_eq("rm_addr", 64'(Address_o), 64'(RST_ADDR));
      rst_n = 1'b1; Ready_i = 1'b1;
      tick();
      check_eq("rm_v1", 64'(Instr_Valid_o), 64'd0);
      tick();
      check_eq("rm_v2", 64'(Instr_Valid_o), 64'd1);
      check_eq("rm_pc", 64'(Pc_o), 64'(RST_ADDR));
      repeat (4) tick();

      check_eq("xfer_count", {63'b0, n_xfer >= 20}, 64'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_instr_fetch_unit
